// File: rtl/spongent_sbox_layer.sv
// SPONGENT sBoxLayer, iterative version.
// A STATE_WIDTH-bit word is loaded, then SBOX_PER_CYCLE nibbles are substituted
// per clock while the word is rotated right, so that after BEATS rotations every
// nibble has been replaced and is back at its original position.
module spongent_sbox_layer #(
    parameter int STATE_WIDTH    = 88,
    parameter int SBOX_PER_CYCLE = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [STATE_WIDTH-1:0] in_data,
    input  logic                   in_inv,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [STATE_WIDTH-1:0] out_data,
    output logic                   busy
);

    localparam int CHUNK = 4 * SBOX_PER_CYCLE;
    localparam int BEATS = STATE_WIDTH / CHUNK;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    // Reject geometries where the S-boxes cannot tile the state exactly.
    generate
        if ((STATE_WIDTH % 4) != 0 || SBOX_PER_CYCLE < 1 ||
            ((STATE_WIDTH / 4) % SBOX_PER_CYCLE) != 0) begin : g_badParams
            $error("spongent_sbox_layer: SBOX_PER_CYCLE must divide STATE_WIDTH/4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_stateNext;
    logic [STATE_WIDTH-1:0] r_data;
    logic                   r_inv;
    logic [CNT_W-1:0]       r_cnt;
    logic [CHUNK-1:0]       w_sub;
    logic [STATE_WIDTH-1:0] w_rot;
    logic                   w_accept;
    logic                   w_lastBeat;

    function automatic logic [3:0] sboxFwd(input logic [3:0] x);
        case (x)
            4'h0: sboxFwd = 4'hE;
            4'h1: sboxFwd = 4'hD;
            4'h2: sboxFwd = 4'hB;
            4'h3: sboxFwd = 4'h0;
            4'h4: sboxFwd = 4'h2;
            4'h5: sboxFwd = 4'h1;
            4'h6: sboxFwd = 4'h4;
            4'h7: sboxFwd = 4'hF;
            4'h8: sboxFwd = 4'h7;
            4'h9: sboxFwd = 4'hA;
            4'hA: sboxFwd = 4'h8;
            4'hB: sboxFwd = 4'h5;
            4'hC: sboxFwd = 4'h9;
            4'hD: sboxFwd = 4'hC;
            4'hE: sboxFwd = 4'h3;
            default: sboxFwd = 4'h6;
        endcase
    endfunction

    function automatic logic [3:0] sboxInv(input logic [3:0] x);
        case (x)
            4'h0: sboxInv = 4'h3;
            4'h1: sboxInv = 4'h5;
            4'h2: sboxInv = 4'h4;
            4'h3: sboxInv = 4'hE;
            4'h4: sboxInv = 4'h6;
            4'h5: sboxInv = 4'hB;
            4'h6: sboxInv = 4'hF;
            4'h7: sboxInv = 4'h8;
            4'h8: sboxInv = 4'hA;
            4'h9: sboxInv = 4'hC;
            4'hA: sboxInv = 4'h9;
            4'hB: sboxInv = 4'h2;
            4'hC: sboxInv = 4'hD;
            4'hD: sboxInv = 4'h1;
            4'hE: sboxInv = 4'h0;
            default: sboxInv = 4'h7;
        endcase
    endfunction

    assign w_accept   = in_valid && in_ready;
    assign w_lastBeat = (r_cnt == CNT_W'(BEATS - 1));

    // Substitute the lowest CHUNK bits of the working word with the latched mode.
    always_comb begin
        w_sub = '0;
        for (int i = 0; i < SBOX_PER_CYCLE; i++) begin
            w_sub[4*i +: 4] = r_inv ? sboxInv(r_data[4*i +: 4]) : sboxFwd(r_data[4*i +: 4]);
        end
    end

    // Rotate right by one chunk, landing the fresh S-box results at the top.
    generate
        if (BEATS == 1) begin : g_rotSingle
            assign w_rot = w_sub;
        end else begin : g_rotMulti
            assign w_rot = {w_sub, r_data[STATE_WIDTH-1:CHUNK]};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic; DONE hands straight over to a new word when one is waiting.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_stateNext = S_BUSY;
            S_BUSY: if (w_lastBeat) w_stateNext = S_DONE;
            S_DONE: begin
                if (out_ready) begin
                    w_stateNext = in_valid ? S_BUSY : S_IDLE;
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            S_IDLE: in_ready = 1'b1;
            S_BUSY: busy = 1'b1;
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Working word, latched mode and beat counter; the word doubles as out_data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data <= '0;
            r_inv  <= 1'b0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_data <= in_data;
            r_inv  <= in_inv;
            r_cnt  <= '0;
        end else if (r_state == S_BUSY) begin
            r_data <= w_rot;
            r_cnt  <= w_lastBeat ? '0 : r_cnt + CNT_W'(1);
        end
    end

    assign out_data = r_data;

endmodule

// File: tb/tb_spongent_sbox_layer.sv
// Scoreboard bench for spongent_sbox_layer: a default 88/2 instance checked
// through an expected-value queue, plus a small 8/1 instance checked directly.
module tb_spongent_sbox_layer;

    localparam int W      = 88;
    localparam int P      = 2;
    localparam int BEATS  = 11;
    localparam int SW     = 8;
    localparam int SP     = 1;

    logic          clk;
    logic          rst_n;
    logic          inValid;
    logic          inReady;
    logic [W-1:0]  inData;
    logic          inInv;
    logic          outValid;
    logic          outReady;
    logic [W-1:0]  outData;
    logic          busy;

    logic          sInValid;
    logic          sInReady;
    logic [SW-1:0] sInData;
    logic          sInInv;
    logic          sOutValid;
    logic          sOutReady;
    logic [SW-1:0] sOutData;
    logic          sBusy;

    typedef struct {
        logic [W-1:0] data;
        int           acceptCyc;
    } expEntry_t;

    expEntry_t sbQ[$];
    int        checks   = 0;
    int        failures = 0;
    int        cyc      = 0;
    bit        awaitRise = 1'b1;
    int        lastAccept;

    logic [3:0] fwdTab [16] = '{4'hE, 4'hD, 4'hB, 4'h0, 4'h2, 4'h1, 4'h4, 4'hF,
                                4'h7, 4'hA, 4'h8, 4'h5, 4'h9, 4'hC, 4'h3, 4'h6};
    logic [3:0] invTab [16] = '{4'h3, 4'h5, 4'h4, 4'hE, 4'h6, 4'hB, 4'hF, 4'h8,
                                4'hA, 4'hC, 4'h9, 4'h2, 4'hD, 4'h1, 4'h0, 4'h7};

    spongent_sbox_layer #(.STATE_WIDTH(W), .SBOX_PER_CYCLE(P)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(inValid), .in_ready(inReady), .in_data(inData), .in_inv(inInv),
        .out_valid(outValid), .out_ready(outReady), .out_data(outData), .busy(busy)
    );

    spongent_sbox_layer #(.STATE_WIDTH(SW), .SBOX_PER_CYCLE(SP)) dutSmall (
        .clk(clk), .rst_n(rst_n),
        .in_valid(sInValid), .in_ready(sInReady), .in_data(sInData), .in_inv(sInInv),
        .out_valid(sOutValid), .out_ready(sOutReady), .out_data(sOutData), .busy(sBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter; reading it at a falling edge gives the number of rising edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [W-1:0] sboxModel(input logic [W-1:0] x, input logic inv);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W / 4; i++) begin
            r[4*i +: 4] = inv ? invTab[x[4*i +: 4]] : fwdTab[x[4*i +: 4]];
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: compares every presented output against the queue head, checks
    // latency on the first valid cycle of each word, pops on handshake.
    always @(negedge clk) begin
        if (rst_n && outValid) begin
            if (sbQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpectedOutput: got 0x%0h, expected no output", outData);
            end else begin
                if (awaitRise) begin
                    checkOutput("latency", W'(cyc - sbQ[0].acceptCyc), W'(BEATS));
                    awaitRise = 1'b0;
                end
                checkOutput("outData", outData, sbQ[0].data);
                if (outReady) begin
                    void'(sbQ.pop_front());
                    awaitRise = 1'b1;
                end
            end
        end
    end

    // Present one word and wait (bounded) for it to be accepted; called just after a rising edge.
    task automatic applyStimulus(input logic [W-1:0] data, input logic inv,
                                 input logic [W-1:0] expected, input bit keepValid,
                                 input bit track);
        bit ok;
        expEntry_t e;
        ok      = 1'b0;
        inValid = 1'b1;
        inData  = data;
        inInv   = inv;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (inReady) begin
                ok = 1'b1;
                lastAccept = cyc + 1;
                if (track) begin
                    e.data      = expected;
                    e.acceptCyc = lastAccept;
                    sbQ.push_back(e);
                end
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("[TB] FAIL acceptTimeout: got in_ready=0 for 200 cycles, expected accept");
        end
        if (!keepValid || !ok) inValid = 1'b0;
    endtask

    task automatic drainQueue();
        int n;
        n = 0;
        while (sbQ.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (sbQ.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drainTimeout: got %0d pending words, expected 0", sbQ.size());
            sbQ.delete();
        end
    endtask

    initial begin
        int busyCnt;
        int lat;
        int waitN;
        logic [SW-1:0] smallOut;
        logic [95:0]   rnd;
        logic [W-1:0]  x;
        logic [W-1:0]  y;
        logic [W-1:0]  rep;
        int            acc [4];

        rst_n     = 1'b0;
        inValid   = 1'b0;
        inData    = '0;
        inInv     = 1'b0;
        outReady  = 1'b1;
        sInValid  = 1'b0;
        sInData   = '0;
        sInInv    = 1'b0;
        sOutReady = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        checkOutput("resetOutValid", W'(outValid), W'(0));
        checkOutput("resetOutData",  outData, '0);
        checkOutput("resetBusy",     W'(busy), W'(0));
        checkOutput("resetInReady",  W'(inReady), W'(1));
        @(posedge clk);
        #1;

        // 8-bit single S-box instance: 0x3A forward -> 0x08 two cycles after accept.
        sInValid = 1'b1;
        sInData  = 8'h3A;
        sInInv   = 1'b0;
        @(negedge clk);
        checkOutput("smallInReady", W'(sInReady), W'(1));
        @(posedge clk);
        #1 sInValid = 1'b0;
        busyCnt  = 0;
        lat      = -1;
        smallOut = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            busyCnt += int'(sBusy);
            if (sOutValid && lat < 0) begin
                lat      = i;
                smallOut = sOutData;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("smallBusyCycles", W'(busyCnt), W'(2));
        checkOutput("smallLatency",    W'(lat), W'(2));
        checkOutput("smallOutData",    W'(smallOut), W'(8'h08));

        // Directed vectors on the 88/2 instance.
        applyStimulus('0, 1'b0, 88'hEEEEEEEEEEEEEEEEEEEEEE, 1'b0, 1'b1);
        applyStimulus(88'h0123456789ABCDEF012345, 1'b0, 88'hEDB0214F7A859C36EDB021, 1'b0, 1'b1);
        applyStimulus(88'h0123456789ABCDEF012345, 1'b1, 88'h354E6BF8AC92D107354E6B, 1'b0, 1'b1);
        applyStimulus(88'hEDB0214F7A859C36EDB021, 1'b1, 88'h0123456789ABCDEF012345, 1'b0, 1'b1);
        drainQueue();

        // Every nibble value, replicated across the word, through both tables.
        for (int n = 0; n < 16; n++) begin
            rep = '0;
            for (int k = 0; k < W / 4; k++) rep[4*k +: 4] = 4'(n);
            y = '0;
            for (int k = 0; k < W / 4; k++) y[4*k +: 4] = fwdTab[n];
            applyStimulus(rep, 1'b0, y, 1'b0, 1'b1);
            for (int k = 0; k < W / 4; k++) y[4*k +: 4] = invTab[n];
            applyStimulus(rep, 1'b1, y, 1'b0, 1'b1);
        end
        drainQueue();

        // Random round trips: forward result fed back through the inverse returns X.
        for (int r = 0; r < 200; r++) begin
            rnd = {$urandom(), $urandom(), $urandom()};
            x   = rnd[W-1:0];
            y   = sboxModel(x, 1'b0);
            applyStimulus(x, 1'b0, y, 1'b0, 1'b1);
            applyStimulus(y, 1'b1, x, 1'b0, 1'b1);
        end
        drainQueue();

        // Backpressure: output held while out_ready is low, input changes ignored.
        outReady = 1'b0;
        applyStimulus(88'h0123456789ABCDEF012345, 1'b0, 88'hEDB0214F7A859C36EDB021, 1'b0, 1'b1);
        waitN = 0;
        while (!outValid && waitN < 50) begin
            @(posedge clk);
            #1;
            waitN++;
        end
        checkOutput("bpReachedDone", W'(outValid), W'(1));
        for (int i = 0; i < 5; i++) begin
            inValid = 1'b1;
            inData  = ~inData;
            inInv   = ~inInv;
            @(negedge clk);
            checkOutput("bpInReady",  W'(inReady), W'(0));
            checkOutput("bpOutValid", W'(outValid), W'(1));
            @(posedge clk);
            #1;
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        drainQueue();

        // Back-to-back: each new word is taken on the DONE edge of the previous one.
        for (int i = 0; i < 4; i++) begin
            rnd = {$urandom(), $urandom(), $urandom()};
            x   = rnd[W-1:0];
            applyStimulus(x, 1'(i & 1), sboxModel(x, 1'(i & 1)), (i != 3), 1'b1);
            acc[i] = lastAccept;
        end
        for (int i = 1; i < 4; i++) begin
            checkOutput("b2bAcceptSpacing", W'(acc[i] - acc[i-1]), W'(BEATS + 1));
        end
        drainQueue();

        // Reset asserted for one edge while the beat counter reads 5.
        applyStimulus(88'h0123456789ABCDEF012345, 1'b0, '0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("midBusyBeforeReset", W'(busy), W'(1));
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midResetOutValid", W'(outValid), W'(0));
        checkOutput("midResetOutData",  outData, '0);
        checkOutput("midResetBusy",     W'(busy), W'(0));
        checkOutput("midResetInReady",  W'(inReady), W'(1));
        @(posedge clk);
        #1;
        applyStimulus(88'h0123456789ABCDEF012345, 1'b1, 88'h354E6BF8AC92D107354E6B, 1'b0, 1'b1);
        drainQueue();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
